// File: rtl/adc_bitslip_aligner.sv
// Per-lane word aligner for the ADC deserializers. Each lane compares its words
// against a training pattern and pulses bitslip until lock, or gives up.
module adc_bitslip_aligner #(
  parameter int                    NUM_CH        = 4,
  parameter int                    DATA_WIDTH    = 8,
  parameter logic [DATA_WIDTH-1:0] TRAIN_PATTERN = DATA_WIDTH'(8'hF0),
  parameter int                    SLIP_WAIT     = 4,
  parameter int                    LOCK_COUNT    = 16,
  parameter int                    MAX_SLIPS     = 8,
  localparam int                   SCW           = $clog2(MAX_SLIPS + 1)
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic [NUM_CH*DATA_WIDTH-1:0] data_i,
  input  logic                         valid_i,
  input  logic                         train_start,
  output logic [NUM_CH-1:0]            bitslip_o,
  output logic [NUM_CH-1:0]            locked_o,
  output logic [NUM_CH-1:0]            fail_o,
  output logic [NUM_CH*SCW-1:0]        slip_cnt_o,
  output logic                         all_locked_o,
  output logic [NUM_CH*DATA_WIDTH-1:0] data_o,
  output logic                         data_valid_o
);

  // state  | meaning
  // IDLE   | waiting for train_start
  // SETTLE | discarding SLIP_WAIT valid words after start or bitslip
  // CHECK  | counting consecutive pattern matches
  // SLIP   | one-cycle bitslip pulse to the deserializer
  // LOCKED | word boundary found, data no longer checked
  // FAIL   | MAX_SLIPS exhausted without lock
  typedef enum logic [2:0] {
    S_IDLE, S_SETTLE, S_CHECK, S_SLIP, S_LOCKED, S_FAIL
  } state_e;

  localparam int WW = $clog2(SLIP_WAIT + 1);
  localparam int MW = $clog2(LOCK_COUNT + 1);

  state_e                  state_q   [NUM_CH];
  state_e                  state_d   [NUM_CH];
  logic [WW-1:0]           wait_q    [NUM_CH];
  logic [WW-1:0]           wait_d    [NUM_CH];
  logic [MW-1:0]           match_q   [NUM_CH];
  logic [MW-1:0]           match_d   [NUM_CH];
  logic [SCW-1:0]          slip_q    [NUM_CH];
  logic [SCW-1:0]          slip_d    [NUM_CH];
  logic [NUM_CH-1:0]       bitslip_q, bitslip_d;
  logic [NUM_CH-1:0]       locked_q,  locked_d;
  logic [NUM_CH-1:0]       fail_q,    fail_d;
  logic [NUM_CH*DATA_WIDTH-1:0] data_q, data_d;
  logic                    data_valid_q, data_valid_d;

  always_comb begin
    for (int k = 0; k < NUM_CH; k++) begin
      state_d[k] = state_q[k];
      wait_d[k]  = wait_q[k];
      match_d[k] = match_q[k];
      slip_d[k]  = slip_q[k];

      if (train_start) begin
        state_d[k] = S_SETTLE;
        wait_d[k]  = WW'(SLIP_WAIT);
        match_d[k] = '0;
        slip_d[k]  = '0;
      end else begin
        case (state_q[k])
          // SLIP lasts one cycle whatever valid_i does, so the pulse width is fixed.
          S_SLIP: begin
            slip_d[k]  = slip_q[k] + SCW'(1);
            wait_d[k]  = WW'(SLIP_WAIT);
            state_d[k] = S_SETTLE;
          end
          S_SETTLE: begin
            if (valid_i) begin
              wait_d[k] = wait_q[k] - WW'(1);
              if (wait_q[k] == WW'(1)) state_d[k] = S_CHECK;
            end
          end
          S_CHECK: begin
            if (valid_i) begin
              if (data_i[k*DATA_WIDTH +: DATA_WIDTH] == TRAIN_PATTERN) begin
                match_d[k] = match_q[k] + MW'(1);
                if (match_q[k] == MW'(LOCK_COUNT - 1)) state_d[k] = S_LOCKED;
              end else begin
                match_d[k] = '0;
                if (slip_q[k] == SCW'(MAX_SLIPS)) state_d[k] = S_FAIL;
                else                              state_d[k] = S_SLIP;
              end
            end
          end
          default: ;
        endcase
      end

      bitslip_d[k] = (state_d[k] == S_SLIP);
      locked_d[k]  = (state_d[k] == S_LOCKED);
      fail_d[k]    = (state_d[k] == S_FAIL);
    end
    data_d       = data_i;
    data_valid_d = valid_i;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int k = 0; k < NUM_CH; k++) begin
        state_q[k] <= S_IDLE;
        wait_q[k]  <= '0;
        match_q[k] <= '0;
        slip_q[k]  <= '0;
      end
      bitslip_q    <= '0;
      locked_q     <= '0;
      fail_q       <= '0;
      data_q       <= '0;
      data_valid_q <= 1'b0;
    end else begin
      for (int k = 0; k < NUM_CH; k++) begin
        state_q[k] <= state_d[k];
        wait_q[k]  <= wait_d[k];
        match_q[k] <= match_d[k];
        slip_q[k]  <= slip_d[k];
      end
      bitslip_q    <= bitslip_d;
      locked_q     <= locked_d;
      fail_q       <= fail_d;
      data_q       <= data_d;
      data_valid_q <= data_valid_d;
    end
  end

  always_comb begin
    for (int k = 0; k < NUM_CH; k++) slip_cnt_o[k*SCW +: SCW] = slip_q[k];
  end

  assign bitslip_o    = bitslip_q;
  assign locked_o     = locked_q;
  assign fail_o       = fail_q;
  assign all_locked_o = &locked_q;
  assign data_o       = data_q;
  assign data_valid_o = data_valid_q;

endmodule

// File: doc/adc_bitslip_aligner.md
Name: adc_bitslip_aligner

Overview:
Multi-channel word-alignment controller for the ADC LVDS capture path. It sits in the CLKDIV domain directly after the per-lane deserializers. For each lane it compares incoming parallel words against a training pattern and issues single-cycle bitslip pulses back to that lane's deserializer until the word boundary is found. Each lane then reports locked or failed, and aligned data is passed downstream with one registered stage.

Parameters:
NUM_CH, 4, number of independent lanes.
DATA_WIDTH, 8, parallel word width per lane (2-14).
TRAIN_PATTERN, 8'hF0, DATA_WIDTH-bit training word expected on every lane.
SLIP_WAIT, 4, valid words discarded after each bitslip or start before comparing; minimum 3.
LOCK_COUNT, 16, consecutive matching words required to declare lock; minimum 1.
MAX_SLIPS, 8, bitslips allowed per lane before declaring failure.

Ports:
CLK  in  1  divided (word) clock; all logic on the rising edge.
RST  in  1  synchronous active-high reset.
data_i  in  NUM_CH*DATA_WIDTH  deserialized words; lane k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
valid_i  in  1  data_i qualifier, common to all lanes.
train_start  in  1  starts or restarts training on all lanes when sampled high.
bitslip_o  out  NUM_CH  one-cycle bitslip pulse per lane, to the deserializer.
locked_o  out  NUM_CH  lane aligned.
fail_o  out  NUM_CH  lane exhausted MAX_SLIPS without lock.
slip_cnt_o  out  NUM_CH*SCW  bitslips issued per lane; SCW = $clog2(MAX_SLIPS+1).
all_locked_o  out  1  AND of locked_o.
data_o  out  NUM_CH*DATA_WIDTH  data_i registered.
data_valid_o  out  1  valid_i registered.

Behaviour:
- Reset: RST sampled high clears every register. All outputs are 0 on the following cycle and every lane is in IDLE. RST dominates train_start and all other inputs.
- Per-lane FSM states: IDLE, SETTLE, CHECK, SLIP, LOCKED, FAIL. Each lane owns its own wait counter, match counter and slip counter.
- Counters advance only on cycles with valid_i=1. With valid_i=0, counters and FSM hold; bitslip_o is unaffected.
- train_start=1 (any state, RST low): next state SETTLE; wait counter loads SLIP_WAIT; match and slip counters clear; locked_o and fail_o clear.
- A bitslip pulse already being driven in the train_start cycle completes; no further pulse follows.
- IDLE: holds until train_start.
- SETTLE: each valid word decrements the wait counter. The word that brings it to 0 moves the lane to CHECK. That word is not compared.
- CHECK, valid word equal to TRAIN_PATTERN: match counter increments. On reaching LOCK_COUNT, the lane goes to LOCKED.
- CHECK, mismatch: the match counter clears, even after partial matches.
  - If slip counter < MAX_SLIPS: go to SLIP.
  - If slip counter = MAX_SLIPS: go to FAIL.
- SLIP: bitslip_o[k]=1 for exactly this one cycle, decoded from the state register (glitch-free). Slip counter increments; wait counter loads SLIP_WAIT; next state SETTLE unconditionally.
- Bitslip latency: mismatch word accepted at cycle N → bitslip_o high at N+1 → lane in SETTLE at N+2.
- Pulse spacing: consecutive pulses on a lane are at least SLIP_WAIT+2 cycles apart, which meets the deserializer's bitslip spacing rule.
- LOCKED: locked_o[k]=1. Data is no longer checked. Held until train_start or RST.
- FAIL: fail_o[k]=1. slip_cnt_o holds MAX_SLIPS. Held until train_start or RST.
- Lanes are fully independent. all_locked_o is a combinational AND of the registered locked_o.
- data_o and data_valid_o register data_i and valid_i every cycle, regardless of FSM state. Latency is 1 cycle; no gating.
- slip_cnt_o never exceeds MAX_SLIPS.

Test Plan:
- Already-aligned lane: RST, then train_start pulse, then data 8'hF0 on all lanes with valid_i=1 → locked_o=4'hF exactly 20 valid cycles after train_start (4 settle + 16 match). No bitslip pulses; slip_cnt_o all 0; all_locked_o=1.
- Rotated lane: bench model rotates lane 1 by one bit per bitslip, starting 3 rotations off → exactly 3 single-cycle pulses on bitslip_o[1], each ≥6 cycles apart. Then slip_cnt_o lane1=3 and locked_o[1]=1; other lanes show no pulses.
- Never-matching lane: lane 2 driven constant 8'h00 → 8 pulses, then fail_o[2]=1 one cycle after the next mismatch; locked_o[2]=0 and all_locked_o stays 0. A new train_start clears fail_o[2] and slip_cnt_o lane2.
- Partial match: lane 0 gets 10 matches, then one mismatch → one bitslip, match count restarts. Lock requires 16 fresh matches after settle.
- Valid gaps: valid_i toggled 1/0 on alternate cycles with aligned data → lock takes 40 cycles. No counter advances while valid_i=0; data_valid_o mirrors valid_i one cycle late.
- Reset mid-training: RST asserted one cycle after a bitslip pulse on lane 3, during SETTLE → next cycle all outputs 0, no further pulses, all lanes IDLE until train_start.
